escaner_teclado_4x4: RTL



---
 rtl/escaner_teclado_4x4.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/escaner_teclado_4x4.sv
// 4x4 matrix keypad scanner: one column driven low per scan tick, rows debounced.
// Optional macro TECLADO_REPEAT_EN adds auto-repeat strobes while a key stays held.
module escaner_teclado_4x4 #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Filas,
    output logic [3:0] o_Columnas,
    output logic [3:0] o_Tecla,
    output logic       o_Valida,
    output logic       o_Presionada
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_FRAMES - 1);
    localparam bit CFG_OK = (SCAN_DIV >= 2) && (DEBOUNCE_FRAMES >= 1)
                            && (REPEAT_FRAMES >= 1);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;

    generate
        if (!CFG_OK) begin : g_cfg_invalid
            $error("escaner_teclado_4x4: invalid parameters");
        end
    endgenerate

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_state;
    logic [1:0]    r_col;
    logic [1:0]    r_fila;
    logic [3:0]    r_code;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_rcnt;

    logic          w_tick;
    logic          w_hay;
    logic          w_fila_baja;
    logic [1:0]    w_fila;
    logic [3:0]    w_code;

`ifdef TECLADO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
    logic [RW-1:0] r_rep;
`endif

    assign o_Columnas  = ~(4'b0001 << r_col);
    assign w_tick      = (r_div == DIV_LAST);
    assign w_hay       = ~&r_sync2;
    assign w_fila_baja = ~r_sync2[r_fila];
    assign w_code      = {w_fila, r_col};

    // Lowest active row wins when several are low in one column.
    always_comb begin
        w_fila = 2'd3;
        if (!r_sync2[0])
            w_fila = 2'd0;
        else if (!r_sync2[1])
            w_fila = 2'd1;
        else if (!r_sync2[2])
            w_fila = 2'd2;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_div   <= '0;
        end else begin
            r_sync1 <= i_Filas;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state      <= S_SCAN;
            r_col        <= 2'd0;
            r_fila       <= 2'd0;
            r_code       <= 4'd0;
            r_cnt        <= '0;
            r_rcnt       <= '0;
            o_Tecla      <= 4'd0;
            o_Valida     <= 1'b0;
            o_Presionada <= 1'b0;
`ifdef TECLADO_REPEAT_EN
            r_rep        <= '0;
`endif
        end else begin
            o_Valida <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_SCAN: begin
                        if (w_hay) begin
                            r_fila <= w_fila;
                            r_code <= w_code;
                            r_cnt  <= CW'(1);
                            if (DEBOUNCE_FRAMES == 1) begin
                                r_state      <= S_HELD;
                                o_Tecla      <= w_code;
                                o_Valida     <= 1'b1;
                                o_Presionada <= 1'b1;
                                r_rcnt       <= '0;
`ifdef TECLADO_REPEAT_EN
                                r_rep        <= '0;
`endif
                            end else begin
                                r_state <= S_DEB;
                            end
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                    S_DEB: begin
                        if (w_fila_baja) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == DEB_LAST) begin
                                r_state      <= S_HELD;
                                o_Tecla      <= r_code;
                                o_Valida     <= 1'b1;
                                o_Presionada <= 1'b1;
                                r_rcnt       <= '0;
`ifdef TECLADO_REPEAT_EN
                                r_rep        <= '0;
`endif
                            end
                        end else begin
                            r_state <= S_SCAN;
                            r_col   <= r_col + 2'd1;
                        end
                    end
                    S_HELD: begin
                        if (!w_fila_baja) begin
                            r_rcnt <= r_rcnt + 1'b1;
`ifdef TECLADO_REPEAT_EN
                            r_rep  <= '0;
`endif
                            if (r_rcnt == DEB_LAST) begin
                                o_Presionada <= 1'b0;
                                r_state      <= S_SCAN;
                                r_col        <= r_col + 2'd1;
                            end
                        end else begin
                            r_rcnt <= '0;
`ifdef TECLADO_REPEAT_EN
                            if (r_rep == REP_LAST) begin
                                r_rep    <= '0;
                                o_Valida <= 1'b1;
                            end else begin
                                r_rep <= r_rep + 1'b1;
                            end
`endif
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

endmodule
